// File: rtl/xt_hb_arbiter.sv
// xt_hb_arbiter: round-robin arbiter sharing one XT high-speed bus master
// port between NUM_MASTERS requesters. A tenure ends when the owner drops
// m_req, or when MAX_HOLD transfers have completed and someone else is
// waiting. Read data is routed back to whichever master issued the read.
// Optional feature macro: XT_HB_ARB_LOCK_EN adds m_lock, which suppresses
// the hold-limit hand-over while the owner asserts it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner, hb_* outputs forced to 0, waiting for any m_req
// OWN   | one master granted; hb_* follow that master's inputs
module xt_hb_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 15,
   parameter int MAX_HOLD    = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_MASTERS-1:0]            m_req,
   input  logic [NUM_MASTERS-1:0]            m_read,
   input  logic [NUM_MASTERS-1:0]            m_write,
   input  logic [2*NUM_MASTERS-1:0]          m_write_width,
   input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_raddr,
   input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_waddr,
   input  logic [32*NUM_MASTERS-1:0]         m_wdata,
`ifdef XT_HB_ARB_LOCK_EN
   input  logic [NUM_MASTERS-1:0]            m_lock,
`endif
   output logic [NUM_MASTERS-1:0]            m_gnt,
   output logic [NUM_MASTERS-1:0]            m_rvalid,
   output logic [31:0]                       m_rdata,
   output logic                              hb_read,
   output logic                              hb_write,
   output logic [1:0]                        hb_write_width,
   output logic [ADDR_WIDTH-1:0]             hb_raddr,
   output logic [ADDR_WIDTH-1:0]             hb_waddr,
   output logic [31:0]                       hb_wdata,
   input  logic                              hb_ready,
   input  logic [31:0]                       hb_rdata
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   typedef enum logic {IDLE, OWN} state_t;

   state_t                 state;
   logic [IW-1:0]          owner;
   logic [IW-1:0]          rr_ptr;
   logic [HW-1:0]          hold_cnt;
   logic [HW-1:0]          hold_nxt;
   logic [IW-1:0]          rd_owner;
   logic                   rd_pend;
   logic                   xfer_done;
   logic                   rd_done;
   logic                   stall;
   logic                   limit_hit;
   logic                   owner_lock;
   logic                   release_now;
   logic [NUM_MASTERS-1:0] others;
   logic [IW-1:0]          idle_pick;
   logic [IW-1:0]          hand_pick;

   // First requester strictly after 'last', wrapping; 'last' itself is checked last.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [IW-1:0] last);
      logic [IW-1:0] pick;
      logic          found;
      int            idx;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = int'(last) + k;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         if (!found && req[idx]) begin
            pick  = IW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IW-1:0] idx);
      return NUM_MASTERS'(1) << idx;
   endfunction

   // AND-OR mux of the granted master's bundle; zero when nobody is granted.
   always_comb begin
      hb_read        = 1'b0;
      hb_write       = 1'b0;
      hb_write_width = '0;
      hb_raddr       = '0;
      hb_waddr       = '0;
      hb_wdata       = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (m_gnt[i]) begin
            hb_read        = hb_read  | (m_read[i]  & m_req[i]);
            hb_write       = hb_write | (m_write[i] & m_req[i]);
            hb_write_width = hb_write_width | m_write_width[2*i +: 2];
            hb_raddr       = hb_raddr | m_raddr[ADDR_WIDTH*i +: ADDR_WIDTH];
            hb_waddr       = hb_waddr | m_waddr[ADDR_WIDTH*i +: ADDR_WIDTH];
            hb_wdata       = hb_wdata | m_wdata[32*i +: 32];
         end
      end
   end

   assign xfer_done = (hb_read | hb_write) & hb_ready;
   assign rd_done   = hb_read & hb_ready;
   assign stall     = (hb_read | hb_write) & ~hb_ready;
   assign others    = m_req & ~m_gnt;
   assign idle_pick = rr_pick(m_req, rr_ptr);
   assign hand_pick = rr_pick(others, owner);

`ifdef XT_HB_ARB_LOCK_EN
   assign owner_lock = m_lock[owner];
`else
   assign owner_lock = 1'b0;
`endif

   // Transfer count including the one completing now, saturating at the limit.
   always_comb begin
      hold_nxt = hold_cnt;
      if (xfer_done && (MAX_HOLD != 0) && (hold_cnt != HW'(MAX_HOLD)))
         hold_nxt = hold_cnt + 1'b1;
   end

   // The limit is judged on the count after this cycle's transfer, so the
   // tenure ends on the edge that completes the last allowed transfer.
   assign limit_hit   = (MAX_HOLD != 0) && (hold_nxt == HW'(MAX_HOLD));
   assign release_now = (state == OWN) &&
                        (!m_req[owner] || (limit_hit && (|others) && !stall && !owner_lock));

   // Tenure FSM: grant, hold counting, round-robin hand-over.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         m_gnt    <= '0;
         owner    <= '0;
         rr_ptr   <= IW'(NUM_MASTERS - 1);
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|m_req) begin
                  owner    <= idle_pick;
                  m_gnt    <= onehot(idle_pick);
                  hold_cnt <= '0;
                  state    <= OWN;
               end
            end
            OWN: begin
               if (release_now) begin
                  rr_ptr   <= owner;
                  hold_cnt <= '0;
                  if (|others) begin
                     owner <= hand_pick;
                     m_gnt <= onehot(hand_pick);
                  end else begin
                     m_gnt <= '0;
                     state <= IDLE;
                  end
               end else begin
                  hold_cnt <= hold_nxt;
               end
            end
            default: begin
               state <= IDLE;
               m_gnt <= '0;
            end
         endcase
      end
   end

   // Remember who issued an accepted read so data returns there even after hand-over.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pend  <= 1'b0;
         rd_owner <= '0;
      end else begin
         rd_pend  <= rd_done;
         rd_owner <= owner;
      end
   end

   assign m_rvalid = rd_pend ? onehot(rd_owner) : '0;
   assign m_rdata  = hb_rdata;

endmodule

// File: tb/tb_xt_hb_arbiter.sv
// Bench for xt_hb_arbiter: directed scenarios followed by random traffic.
// A reference model tracks ownership from the arbitration rules and pushes
// expected read returns into a scoreboard that a separate monitor drains.
module tb_xt_hb_arbiter;
   localparam int N  = 3;
   localparam int AW = 15;
   localparam int MH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      m_req, m_read, m_write;
   logic [2*N-1:0]    m_write_width;
   logic [AW*N-1:0]   m_raddr, m_waddr;
   logic [32*N-1:0]   m_wdata;
   logic [N-1:0]      m_lock;
   logic [N-1:0]      m_gnt, m_rvalid;
   logic [31:0]       m_rdata;
   logic              hb_read, hb_write;
   logic [1:0]        hb_write_width;
   logic [AW-1:0]     hb_raddr, hb_waddr;
   logic [31:0]       hb_wdata;
   logic              hb_ready;
   logic [31:0]       hb_rdata;

   xt_hb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req(m_req), .m_read(m_read), .m_write(m_write),
      .m_write_width(m_write_width), .m_raddr(m_raddr), .m_waddr(m_waddr),
      .m_wdata(m_wdata),
`ifdef XT_HB_ARB_LOCK_EN
      .m_lock(m_lock),
`endif
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .hb_read(hb_read), .hb_write(hb_write), .hb_write_width(hb_write_width),
      .hb_raddr(hb_raddr), .hb_waddr(hb_waddr), .hb_wdata(hb_wdata),
      .hb_ready(hb_ready), .hb_rdata(hb_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          m;
      logic [31:0] data;
      int          due;
   } rd_item_t;

   rd_item_t    sb[$];
   rd_item_t    it;
   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   bit          model_en = 1'b0;
   bit          force_rd = 1'b0;
   logic [31:0] force_val = '0;
   logic [31:0] rdata_nxt = '0;

   // Reference model state: owner index (-1 = none), transfers this tenure, last owner.
   int          own  = -1;
   int          hold = 0;
   int          last = N - 1;
   logic        e_rd, e_wr, xfer, lk;
   logic [N-1:0] oth;
   logic [63:0] exp_bus;
   logic [N-1:0] g_seen [0:15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   function automatic int rr_next(input logic [N-1:0] req, input int after);
      for (int k = 1; k <= N; k++) begin
         int idx = (after + k) % N;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   always @(posedge clk) cyc++;

   // Reference model: compare grant and bus, then advance one clock of the rules.
   always @(negedge clk) begin
      if (model_en) begin
         check("m_gnt", 64'(m_gnt), 64'(oh(own)));
         e_rd = 1'b0;
         e_wr = 1'b0;
         if (own >= 0) begin
            e_rd = m_read[own] & m_req[own];
            e_wr = m_write[own] & m_req[own];
            exp_bus = {m_raddr[own*AW +: AW], m_waddr[own*AW +: AW],
                       m_wdata[own*32 +: 32], m_write_width[own*2 +: 2]};
         end else begin
            exp_bus = '0;
         end
         check("hb_strobes", 64'({hb_read, hb_write}), 64'({e_rd, e_wr}));
         check("hb_bus", {hb_raddr, hb_waddr, hb_wdata, hb_write_width}, exp_bus);
         rdata_nxt = force_rd ? force_val : $urandom;
         if (!rst_n) begin
            own  = -1;
            hold = 0;
            last = N - 1;
         end else if (own < 0) begin
            if (m_req != '0) begin
               own  = rr_next(m_req, last);
               hold = 0;
            end
         end else begin
            xfer = e_rd | e_wr;
            if (e_rd && hb_ready) sb.push_back('{own, rdata_nxt, cyc + 1});
            if (xfer && hb_ready && hold < MH) hold++;
`ifdef XT_HB_ARB_LOCK_EN
            lk = m_lock[own];
`else
            lk = 1'b0;
`endif
            oth = m_req & ~oh(own);
            if (!m_req[own] ||
                (MH != 0 && hold >= MH && oth != '0 && !(xfer && !hb_ready) && !lk)) begin
               last = own;
               hold = 0;
               own  = (oth != '0) ? rr_next(oth, own) : -1;
            end
         end
      end
   end

   // Monitor: whenever the DUT presents read data, pop and compare.
   always @(negedge clk) begin
      if (model_en) begin
         if (m_rvalid != '0) begin
            if (sb.size() == 0) begin
               check("rvalid_unexpected", 64'(m_rvalid), 64'(0));
            end else begin
               it = sb.pop_front();
               check("rvalid_cycle", 64'(cyc), 64'(it.due));
               check("rvalid_master", 64'(m_rvalid), 64'(oh(it.m)));
               check("rdata", 64'(m_rdata), 64'(it.data));
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            check("rvalid_missing", 64'(m_rvalid), 64'(oh(it.m)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      hb_rdata = rdata_nxt;
   endtask

   task automatic set_master(input int i, input logic rq, input logic rd, input logic wr);
      m_req[i]   = rq;
      m_read[i]  = rd;
      m_write[i] = wr;
      m_raddr[i*AW +: AW]    = AW'(32'h0100 + 32'(i) * 32'h10);
      m_waddr[i*AW +: AW]    = AW'(32'h0200 + 32'(i) * 32'h10);
      m_wdata[i*32 +: 32]    = 32'hA000_0000 + 32'(i);
      m_write_width[i*2 +: 2] = 2'(i);
   endtask

   task automatic all_idle();
      for (int i = 0; i < N; i++) set_master(i, 1'b0, 1'b0, 1'b0);
      m_lock = '0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      hb_ready = 1'b1;
      hb_rdata = '0;
      all_idle();
      tick();
      tick();
      model_en = 1'b1;
      check("reset_gnt", 64'(m_gnt), 64'(0));
      check("reset_rvalid", 64'(m_rvalid), 64'(0));
      rst_n = 1'b1;

      // Single read by master 0.
      set_master(0, 1'b1, 1'b0, 1'b0);
      tick();
      check("t1_gnt", 64'(m_gnt), 64'(3'b001));
      m_read[0] = 1'b1;
      force_rd  = 1'b1;
      force_val = 32'hDEAD_BEEF;
      tick();
      check("t1_rvalid", 64'(m_rvalid), 64'(3'b001));
      check("t1_rdata", 64'(m_rdata), 64'(32'hDEAD_BEEF));
      force_rd = 1'b0;
      all_idle();
      tick();

      // Two masters writing continuously: four-transfer tenures, no bubble.
      pulse_reset();
      set_master(0, 1'b1, 1'b0, 1'b1);
      set_master(1, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 14; k++) begin
         tick();
         g_seen[k] = m_gnt;
      end
      for (int k = 0; k < 14; k++)
         check("t2_alternate", 64'(g_seen[k]), 64'(((k / 4) % 2 == 0) ? 3'b001 : 3'b010));

      // Continuous reads: the final read of master 1 returns in the switch cycle.
      pulse_reset();
      set_master(0, 1'b1, 1'b1, 1'b0);
      set_master(1, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) tick();
      check("t3_gnt", 64'(m_gnt), 64'(3'b001));
      check("t3_rvalid", 64'(m_rvalid), 64'(3'b010));
      all_idle();
      tick();
      tick();

      // Stall at the hold limit keeps the grant until the write completes.
      pulse_reset();
      set_master(0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) tick();
      set_master(1, 1'b1, 1'b0, 1'b1);
      hb_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t4_stall_gnt", 64'(m_gnt), 64'(3'b001));
      end
      hb_ready = 1'b1;
      tick();
      check("t4_handover", 64'(m_gnt), 64'(3'b010));

      // Reset in the cycle a read is accepted: grant and read return are dropped.
      set_master(1, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      tick();
      check("t5_gnt", 64'(m_gnt), 64'(0));
      check("t5_rvalid", 64'(m_rvalid), 64'(0));
      rst_n = 1'b1;
      set_master(0, 1'b1, 1'b0, 1'b0);
      set_master(1, 1'b1, 1'b0, 1'b0);
      tick();
      check("t5_first", 64'(m_gnt), 64'(3'b001));
      all_idle();
      tick();
      tick();

`ifdef XT_HB_ARB_LOCK_EN
      // Locked owner keeps the bus past the hold limit.
      pulse_reset();
      set_master(0, 1'b1, 1'b0, 1'b1);
      set_master(1, 1'b1, 1'b0, 1'b1);
      m_lock = 3'b001;
      tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         check("lock_hold", 64'(m_gnt), 64'(3'b001));
      end
      m_lock = '0;
      set_master(0, 1'b0, 1'b0, 1'b0);
      tick();
      check("lock_release", 64'(m_gnt), 64'(3'b010));
      all_idle();
      tick();
`endif

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(7) == 0) m_req[i] = ~m_req[i];
            m_read[i]  = 1'($urandom_range(1));
            m_write[i] = 1'($urandom_range(1));
            m_raddr[i*AW +: AW]     = AW'($urandom);
            m_waddr[i*AW +: AW]     = AW'($urandom);
            m_wdata[i*32 +: 32]     = $urandom;
            m_write_width[i*2 +: 2] = 2'($urandom);
            m_lock[i]  = ($urandom_range(3) == 0);
         end
         hb_ready = ($urandom_range(3) != 0);
         rst_n    = ($urandom_range(299) != 0);
         tick();
      end
      rst_n    = 1'b1;
      hb_ready = 1'b1;
      all_idle();
      tick();
      tick();
      tick();
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/xt_hb_arbiter.md
Name: xt_hb_arbiter

Overview:
- Round-robin arbiter sharing one XT high-speed bus (HB) master port between NUM_MASTERS requesters (CPU data port, DMA, debug module).
- Sits between the requesters and the HB address decoder. Drives the single master-in bundle: write_width, read, write, raddr, waddr, wdata.
- Grants the bus per tenure. Routes read data back to the issuing master.
- Limits tenure length so no requester starves the others.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_WIDTH, 15, HB byte-address width; equals HB_ADDR_WIDTH.
- MAX_HOLD, 4, completed transfers allowed per tenure before forced hand-over when another request is pending; 0 = unlimited.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- m_req  in  NUM_MASTERS  bus request per master.
- m_read  in  NUM_MASTERS  read strobe per master.
- m_write  in  NUM_MASTERS  write strobe per master.
- m_write_width  in  2*NUM_MASTERS  write width per master.
- m_raddr  in  ADDR_WIDTH*NUM_MASTERS  read address per master.
- m_waddr  in  ADDR_WIDTH*NUM_MASTERS  write address per master.
- m_wdata  in  32*NUM_MASTERS  write data per master.
- m_gnt  out  NUM_MASTERS  one-hot grant, registered.
- m_rvalid  out  NUM_MASTERS  read data valid for master i, one cycle.
- m_rdata  out  32  shared read data, equals hb_rdata.
- hb_read  out  1  HB read strobe.
- hb_write  out  1  HB write strobe.
- hb_write_width  out  2  HB write width.
- hb_raddr  out  ADDR_WIDTH  HB read address.
- hb_waddr  out  ADDR_WIDTH  HB write address.
- hb_wdata  out  32  HB write data.
- hb_ready  in  1  slave accepts the current transfer this cycle.
- hb_rdata  in  32  slave read data, valid the cycle after an accepted read.

Behaviour:
- Interface clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: m_gnt=0, m_rvalid=0, state=IDLE, hold_cnt=0, rr pointer set so that master 0 has top priority.
- HB outputs are a combinational mux of the owner's inputs, gated by the grant.
  - With no owner, all hb_* outputs are 0.
  - hb_read/hb_write = owner's m_read/m_write AND m_req.
- A transfer completes in a cycle where (hb_read|hb_write) & hb_ready. hb_read and hb_write may be asserted together and count as one transfer.
- A master drives strobes only while its m_gnt=1. Strobes from ungranted masters are ignored.
- State IDLE:
  - If any m_req is high, the RR winner becomes owner next cycle: state OWN, m_gnt one-hot, hold_cnt=0.
  - RR winner = first requester after the last owner, wrapping modulo NUM_MASTERS.
  - Request-to-grant latency is 1 cycle.
- State OWN:
  - hold_cnt increments on each completed transfer and saturates at MAX_HOLD.
  - Owner m_req low -> release.
  - hold_cnt==MAX_HOLD (MAX_HOLD!=0) and another m_req high -> forced release.
  - A transfer completing in the release cycle still counts and is not lost.
  - On release:
    - If another request is pending, grant the RR winner directly next cycle with no idle bubble.
    - Otherwise go to IDLE.
    - The rr pointer updates to the released owner.
  - Owner alone with hold limit reached: keeps the grant (no other requester, no hand-over).
- Read return:
  - Register rd_owner and rd_pend on each completed read.
  - Next cycle: m_rvalid[rd_owner]=1 and m_rdata=hb_rdata.
  - Read data is delivered even if the grant has already moved on. Back-to-back reads give back-to-back rvalid.
- hb_ready low stalls the transfer. Strobes and addresses are held by the master, and the grant cannot be forced away mid-stall.
- Reset mid-tenure clears the grant and any pending rvalid. The lost read is the master's responsibility.

Optional Feature:
- Macro: XT_HB_ARB_LOCK_EN.
- Defined:
  - Adds input m_lock [NUM_MASTERS].
  - While the owner holds m_lock=1, the MAX_HOLD forced release is suppressed; release happens only on m_req low.
  - Used for atomic read-modify-write sequences.
  - Lock asserted by non-owners is ignored.
- Undefined:
  - Port absent.
  - Hold limit always applies.

Test Plan:
- Reset then m_req=01 -> m_gnt=01 one cycle later. Master 0 reads 0x0100 with hb_ready=1 and hb_rdata=0xDEADBEEF -> m_rvalid=01 and m_rdata=0xDEADBEEF the next cycle.
- m_req=11 held, both masters issuing continuous writes, MAX_HOLD=4 -> grant alternates 01,10,01, with exactly 4 writes per tenure and no idle cycle between tenures.
- Master 1 read accepted in its final tenure cycle, grant switches to master 0 -> m_rvalid=10 in the switch cycle and master 0 receives no rvalid.
- hb_ready=0 for 3 cycles during master 0 write with hold_cnt=3 and master 1 requesting -> grant stays 01 until the write completes, then moves to 10.
- rst_n=0 during OWN with a read pending -> m_gnt=0 and m_rvalid=0 next cycle; after reset, m_req=11 -> master 0 granted first.
- XT_HB_ARB_LOCK_EN defined, master 0 with m_lock=1 does 10 writes while master 1 requests -> grant held throughout; m_lock=0 and m_req=0 -> master 1 granted.
